// File: rtl/ifetch_queue.sv
// Instruction fetch unit: direct-mapped I-cache (one instruction per line) feeding a FIFO
// instruction queue toward the Dispatcher, with predictor-steered prefetch and ROB redirect.
module ifetch_queue #(
  parameter int ADDR_W     = 32,
  parameter int INS_W      = 32,
  parameter int IC_IDX_W   = 6,
  parameter int IQ_DEPTH_W = 3,
  parameter int ICACHE_EN  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  output logic                  mem_req_valid,
  output logic [ADDR_W-1:0]     mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [INS_W-1:0]      mem_resp_ins,
  output logic [ADDR_W-1:0]     pred_pc,
  output logic [INS_W-1:0]      pred_ins,
  input  logic                  pred_taken,
  input  logic [ADDR_W-1:0]     pred_target,
  output logic                  disp_valid,
  input  logic                  disp_ready,
  output logic [ADDR_W-1:0]     disp_pc,
  output logic [INS_W-1:0]      disp_ins,
  output logic                  disp_pred_taken,
  output logic [ADDR_W-1:0]     disp_pred_pc,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     flush_pc,
  input  logic                  icache_inv,
  output logic [IQ_DEPTH_W:0]   iq_count
);

  localparam int IC_LINES = 1 << IC_IDX_W;
  localparam int DEPTH    = 1 << IQ_DEPTH_W;
  localparam int TAG_W    = ADDR_W - IC_IDX_W - 2;
  localparam bit CACHE_ON = (ICACHE_EN != 0);
  localparam logic [IQ_DEPTH_W:0]   DEPTH_C = (IQ_DEPTH_W+1)'(DEPTH);
  localparam logic [IQ_DEPTH_W:0]   CNT_ONE = (IQ_DEPTH_W+1)'(1);
  localparam logic [IQ_DEPTH_W-1:0] PTR_ONE = IQ_DEPTH_W'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
    logic              taken;
    logic [ADDR_W-1:0] tgt;
  } iq_entry_t;

  typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic                  req_v_d;
  logic [ADDR_W-1:0]     req_a_d;

  logic [IC_LINES-1:0]   ic_valid;
  logic [TAG_W-1:0]      ic_tag  [IC_LINES];
  logic [INS_W-1:0]      ic_data [IC_LINES];

  iq_entry_t             iq_mem [DEPTH];
  logic [IQ_DEPTH_W-1:0] iq_head, iq_tail;
  logic [IQ_DEPTH_W:0]   iq_cnt;

  logic [IC_IDX_W-1:0]   lk_idx, fill_idx;
  logic [TAG_W-1:0]      lk_tag, fill_tag;
  logic                  ic_hit, iq_space, push, pop, fill;
  iq_entry_t             push_e, head_e;

  assign lk_idx   = pc_q[IC_IDX_W+1:2];
  assign lk_tag   = pc_q[ADDR_W-1:IC_IDX_W+2];
  assign fill_idx = mem_req_addr[IC_IDX_W+1:2];
  assign fill_tag = mem_req_addr[ADDR_W-1:IC_IDX_W+2];
  assign ic_hit   = CACHE_ON && ic_valid[lk_idx] && (ic_tag[lk_idx] == lk_tag);
  assign iq_space = (iq_cnt < DEPTH_C);

  // Predictor sees whichever instruction could be enqueued this cycle.
  always_comb begin
    pred_pc  = '0;
    pred_ins = '0;
    case (state_q)
      IDLE: begin
        pred_pc  = pc_q;
        pred_ins = ic_hit ? ic_data[lk_idx] : '0;
      end
      MISS: begin
        pred_pc  = mem_req_addr;
        pred_ins = mem_resp_ins;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_v_d = mem_req_valid;
    req_a_d = mem_req_addr;
    push    = 1'b0;
    fill    = 1'b0;
    push_e  = '{pc: pred_pc, ins: pred_ins, taken: pred_taken, tgt: pred_target};
    case (state_q)
      IDLE: begin
        if (flush) begin
          pc_d = flush_pc;
        end else if (iq_space) begin
          if (ic_hit) begin
            push = 1'b1;
            pc_d = pred_target;
          end else begin
            req_v_d = 1'b1;
            req_a_d = pc_q;
            state_d = MISS;
          end
        end
      end
      MISS: begin
        if (mem_resp_valid) begin
          fill    = 1'b1;
          req_v_d = 1'b0;
          state_d = IDLE;
          if (flush) pc_d = flush_pc;
          else begin
            push = 1'b1;
            pc_d = pred_target;
          end
        end else if (flush) begin
          pc_d    = flush_pc;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Outstanding wrong-path response still fills the cache but is never queued.
        if (flush) pc_d = flush_pc;
        if (mem_resp_valid) begin
          fill    = 1'b1;
          req_v_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign disp_valid = (iq_cnt != '0);
  assign pop        = disp_valid && disp_ready && !flush;
  assign head_e     = iq_mem[iq_head];

  assign disp_pc         = disp_valid ? head_e.pc    : '0;
  assign disp_ins        = disp_valid ? head_e.ins   : '0;
  assign disp_pred_taken = disp_valid && head_e.taken;
  assign disp_pred_pc    = disp_valid ? head_e.tgt   : '0;
  assign iq_count        = iq_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      ic_valid      <= '0;
      iq_head       <= '0;
      iq_tail       <= '0;
      iq_cnt        <= '0;
    end else if (rdy) begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_req_valid <= req_v_d;
      mem_req_addr  <= req_a_d;
      // Invalidate wins over a same-cycle fill.
      if (icache_inv)                ic_valid           <= '0;
      else if (fill && CACHE_ON)     ic_valid[fill_idx] <= 1'b1;
      if (flush) begin
        iq_head <= '0;
        iq_tail <= '0;
        iq_cnt  <= '0;
      end else begin
        if (push) iq_tail <= iq_tail + PTR_ONE;
        if (pop)  iq_head <= iq_head + PTR_ONE;
        case ({push, pop})
          2'b10:   iq_cnt <= iq_cnt + CNT_ONE;
          2'b01:   iq_cnt <= iq_cnt - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

  // Storage arrays carry no reset; their contents are qualified by valid bits / count.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (fill && CACHE_ON) begin
        ic_tag[fill_idx]  <= fill_tag;
        ic_data[fill_idx] <= mem_resp_ins;
      end
      if (push && !flush) iq_mem[iq_tail] <= push_e;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue/cache model checked every cycle plus directed literal checks,
// and a second cache-disabled instance for the bypass and mid-miss reset cases.
module tb_ifetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, rdy = 1'b1;
  logic        mem_req_valid, mem_resp_valid = 1'b0;
  logic [31:0] mem_req_addr, mem_resp_ins = '0;
  logic [31:0] pred_pc, pred_ins, pred_target, disp_pc, disp_ins, disp_pred_pc;
  logic        pred_taken, disp_valid, disp_ready = 1'b0, disp_pred_taken;
  logic        flush = 1'b0, icache_inv = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [3:0]  iq_count;
  bit          loop_mode = 1'b0;

  logic        nc_rst = 1'b0;
  logic        nc_mem_req_valid, nc_mem_resp_valid = 1'b0;
  logic [31:0] nc_mem_req_addr, nc_mem_resp_ins = '0;
  logic [31:0] nc_pred_pc, nc_pred_ins, nc_pred_target, nc_disp_pc, nc_disp_ins, nc_disp_pred_pc;
  logic        nc_pred_taken, nc_disp_valid, nc_disp_pred_taken;
  logic [3:0]  nc_iq_count;

  int tests = 0, fails = 0;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign pred_target    = (loop_mode && pred_pc == 32'h10) ? 32'h10 : pred_pc + 32'd4;
  assign pred_taken     = (pred_target != pred_pc + 32'd4);
  assign nc_pred_target = 32'h10;
  assign nc_pred_taken  = (nc_pred_pc + 32'd4 != 32'h10);

  ifetch_queue #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ins(mem_resp_ins),
    .pred_pc(pred_pc), .pred_ins(pred_ins), .pred_taken(pred_taken), .pred_target(pred_target),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc), .disp_ins(disp_ins),
    .disp_pred_taken(disp_pred_taken), .disp_pred_pc(disp_pred_pc),
    .flush(flush), .flush_pc(flush_pc), .icache_inv(icache_inv), .iq_count(iq_count));

  ifetch_queue #(.ICACHE_EN(0), .RESET_PC(32'h0)) u_nc (
    .clk(clk), .rst(nc_rst), .rdy(1'b1),
    .mem_req_valid(nc_mem_req_valid), .mem_req_addr(nc_mem_req_addr),
    .mem_resp_valid(nc_mem_resp_valid), .mem_resp_ins(nc_mem_resp_ins),
    .pred_pc(nc_pred_pc), .pred_ins(nc_pred_ins), .pred_taken(nc_pred_taken), .pred_target(nc_pred_target),
    .disp_valid(nc_disp_valid), .disp_ready(1'b1), .disp_pc(nc_disp_pc), .disp_ins(nc_disp_ins),
    .disp_pred_taken(nc_disp_pred_taken), .disp_pred_pc(nc_disp_pred_pc),
    .flush(1'b0), .flush_pc(32'h0), .icache_inv(1'b0), .iq_count(nc_iq_count));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // MemCtrl stand-ins: fixed latency of 3 cycles from request to response pulse.
  int rcnt, nrcnt;
  always @(negedge clk) begin
    if (!rst) begin rcnt = 0; mem_resp_valid = 1'b0; end
    else if (mem_resp_valid) begin mem_resp_valid = 1'b0; rcnt = 0; end
    else if (mem_req_valid) begin
      rcnt++;
      if (rcnt == 3) begin mem_resp_valid = 1'b1; mem_resp_ins = ins_of(mem_req_addr); end
    end else rcnt = 0;
  end

  always @(negedge clk) begin
    if (!nc_rst) begin nrcnt = 0; nc_mem_resp_valid = 1'b0; end
    else if (nc_mem_resp_valid) begin nc_mem_resp_valid = 1'b0; nrcnt = 0; end
    else if (nc_mem_req_valid) begin
      nrcnt++;
      if (nrcnt == 3) begin nc_mem_resp_valid = 1'b1; nc_mem_resp_ins = ins_of(nc_mem_req_addr); end
    end else nrcnt = 0;
  end

  logic [31:0] nc_log[$];
  always @(posedge clk) if (nc_rst && nc_mem_resp_valid) nc_log.push_back(nc_mem_req_addr);

  // Model: queue of entries, cache as index -> resident address, fetch pc and outstanding miss.
  typedef struct { logic [31:0] pc, ins, tgt; logic tk; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_line[int];
  logic [31:0] m_pc, m_paddr;
  bit          m_pend, m_drain;

  function automatic ent_t mk(input logic [31:0] p);
    ent_t e;
    e.pc  = p;
    e.ins = ins_of(p);
    e.tgt = (loop_mode && p == 32'h10) ? 32'h10 : p + 32'd4;
    e.tk  = (e.tgt != p + 32'd4);
    return e;
  endfunction

  always @(posedge clk) begin : model
    int n;
    bit hit, do_push, do_fill;
    ent_t e;
    logic [31:0] fa;
    if (!rst) begin
      m_q.delete(); m_line.delete();
      m_pc = '0; m_paddr = '0; m_pend = 1'b0; m_drain = 1'b0;
    end else if (rdy) begin
      n = m_q.size();
      hit = m_line.exists(int'(m_pc[7:2])) && (m_line[int'(m_pc[7:2])] == m_pc);
      do_push = 1'b0; do_fill = 1'b0; fa = m_paddr;
      if (!m_pend) begin
        if (flush) m_pc = flush_pc;
        else if (n < 8) begin
          if (hit) begin e = mk(m_pc); do_push = 1'b1; m_pc = e.tgt; end
          else begin m_pend = 1'b1; m_paddr = m_pc; end
        end
      end else if (mem_resp_valid) begin
        do_fill = 1'b1;
        if (!m_drain && !flush) begin e = mk(m_paddr); do_push = 1'b1; m_pc = e.tgt; end
        if (flush) m_pc = flush_pc;
        m_pend = 1'b0; m_drain = 1'b0;
      end else if (flush) begin
        m_pc = flush_pc; m_drain = 1'b1;
      end
      if (icache_inv) m_line.delete();
      else if (do_fill) m_line[int'(fa[7:2])] = fa;
      if (flush) m_q.delete();
      else begin
        if (n > 0 && disp_ready) void'(m_q.pop_front());
        if (do_push) m_q.push_back(e);
      end
    end
    #1;
    if (rst) begin
      chk("disp_valid", disp_valid, m_q.size() > 0);
      chk("iq_count", iq_count, m_q.size());
      if (m_q.size() > 0) begin
        chk("disp_pc", disp_pc, m_q[0].pc);
        chk("disp_ins", disp_ins, m_q[0].ins);
        chk("disp_pred_taken", disp_pred_taken, m_q[0].tk);
        chk("disp_pred_pc", disp_pred_pc, m_q[0].tgt);
      end
      chk("mem_req_valid", mem_req_valid, m_pend);
      if (m_pend) chk("mem_req_addr", mem_req_addr, m_paddr);
      if (!m_pend) chk("pred_pc_idle", pred_pc, m_pc);
      else if (!m_drain) chk("pred_pc_miss", pred_pc, m_paddr);
    end
  end

  task automatic wait_resp(input string nm);
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (mem_resp_valid) break;
    end
    if (i >= 60) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_req(input string nm, input logic [31:0] addr, input bit any);
    int i;
    for (i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (mem_req_valid && (any || mem_req_addr == addr)) break;
    end
    if (i >= 80) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int i;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_iq_count", iq_count, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_pred_pc", pred_pc, 0);
    chk("rst_pred_ins", pred_ins, 0);
    rst = 1'b1; nc_rst = 1'b1;

    // Cold start: three sequential misses, each visible one cycle after its response.
    for (int k = 0; k < 3; k++) begin
      wait_resp("cold_resp");
      chk("cold_req_addr", mem_req_addr, 32'(4 * k));
      if (k == 0) chk("cold_no_bypass", disp_valid, 0);
      @(posedge clk); #1;
      chk("cold_disp_valid", disp_valid, 1);
      chk("cold_iq_count", iq_count, 4'(k + 1));
    end
    chk("cold_head_pc", disp_pc, 32'h0);
    chk("cold_head_ins", disp_ins, 32'h1357_9BDF);

    // Self-loop at 0x10: cache-fed enqueue until full.
    loop_mode = 1'b1;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (iq_count == 4'd8) break;
    end
    if (i >= 60) chk("fill_to_full_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("full_iq_count", iq_count, 8);
    chk("full_no_req", mem_req_valid, 0);
    chk("full_head_pc", disp_pc, 32'h0);
    disp_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("stream_iq_count", iq_count, 7);
    chk("stream_head_pc", disp_pc, 32'h10);
    chk("stream_head_taken", disp_pred_taken, 1);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    rdy = 1'b1;
    repeat (2) @(negedge clk);

    // Invalidate: lookup that cycle still hits, the following fetch of 0x10 misses.
    icache_inv = 1'b1;
    @(negedge clk);
    icache_inv = 1'b0;
    @(posedge clk); #1;
    chk("inv_req_valid", mem_req_valid, 1);
    chk("inv_req_addr", mem_req_addr, 32'h10);
    wait_resp("inv_resp");
    loop_mode = 1'b0;

    // Flush during the 0x20 miss: response fills but is not queued; refetch from 0x100.
    wait_req("req20", 32'h20, 1'b0);
    flush = 1'b1; flush_pc = 32'h100; disp_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_iq_count", iq_count, 0);
    chk("flush_disp_valid", disp_valid, 0);
    chk("drain_req_held", mem_req_valid, 1);
    chk("drain_req_addr", mem_req_addr, 32'h20);
    wait_resp("drain_resp");
    @(posedge clk); #1;
    chk("drain_no_push", iq_count, 0);
    wait_req("req100", 32'h0, 1'b1);
    chk("redirect_req_addr", mem_req_addr, 32'h100);

    // Flush coincident with a response: no push, then 0x20 hits in the drained-in line.
    wait_resp("resp100");
    flush = 1'b1; flush_pc = 32'h20;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("coinc_iq_count", iq_count, 0);
    chk("coinc_req_valid", mem_req_valid, 0);
    chk("coinc_pred_pc", pred_pc, 32'h20);
    @(negedge clk); #1;
    chk("coinc_hit_count", iq_count, 1);
    chk("coinc_hit_pc", disp_pc, 32'h20);
    chk("coinc_hit_ins", disp_ins, ins_of(32'h20));
    chk("coinc_hit_no_req", mem_req_valid, 0);
    disp_ready = 1'b1;
    repeat (20) @(negedge clk);

    // Cache-disabled instance: every fetch of 0x10 goes to memory.
    chk("nc_resp_count", nc_log.size() >= 4, 1);
    for (int k = 0; k < 4 && k < nc_log.size(); k++)
      chk("nc_req_addr", nc_log[k], (k == 0) ? 32'h0 : 32'h10);
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (nc_mem_req_valid) break;
    end
    if (i >= 40) chk("nc_miss_timeout", 0, 1);
    nc_rst = 1'b0;
    #1;
    chk("nc_rst_req_valid", nc_mem_req_valid, 0);
    chk("nc_rst_req_addr", nc_mem_req_addr, 0);
    chk("nc_rst_disp_valid", nc_disp_valid, 0);
    chk("nc_rst_iq_count", nc_iq_count, 0);
    chk("nc_rst_pred_pc", nc_pred_pc, 0);
    chk("nc_rst_pred_ins", nc_pred_ins, 0);
    chk("nc_rst_disp_pc", nc_disp_pc, 0);
    @(negedge clk);
    nc_rst = 1'b1;
    @(posedge clk); #1;
    chk("nc_restart_req", nc_mem_req_valid, 1);
    chk("nc_restart_addr", nc_mem_req_addr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
